// File: rtl/encoder_8x3_pending_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : encoder_pkg
// Brief  : Shared types, default sizes and helpers for the sticky-request
//          priority encoder.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package encoder_pkg;

  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = $clog2(N_DEF);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } enc_state_t;

  // One-hot mask for an index. The result is 32 bits wide so that any
  // request count up to 32 can truncate it to its own width.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx[4:0];
  endfunction

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/encoder_8x3_pending_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : encoder_8x3_pending_if
// Brief  : Request lines, valid/ready index output and status for the
//          sticky-request priority encoder.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
interface encoder_8x3_pending_if #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
);

  logic [N-1:0]     req_in;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     pend_o;
  logic             drop_o;

  // Event sources and the consumer: drive requests and ready.
  modport master (
    output req_in,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  pend_o,
    input  drop_o
  );

  // The encoder itself.
  modport slave (
    input  req_in,
    input  out_ready,
    output out_valid,
    output out_idx,
    output pend_o,
    output drop_o
  );

endinterface : encoder_8x3_pending_if
`default_nettype wire

// File: rtl/encoder_8x3_pending_prio.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : prio_enc_comb
// Brief  : Combinational priority encoder. MSB_FIRST=1 reports the highest
//          set bit, MSB_FIRST=0 the lowest. idx_o is 0 when nothing is set.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module prio_enc_comb #(
  parameter int N         = 8,
  parameter int IDX_W     = $clog2(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic [N-1:0]     vec_i,
  output logic      [IDX_W-1:0] idx_o,
  output logic                  any_o
);

  assign any_o = |vec_i;

  generate
    if (MSB_FIRST) begin : g_msb_first
      // Scan upward; the last set bit seen is the highest one.
      always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
          if (vec_i[i]) idx_o = IDX_W'(i);
        end
      end
    end else begin : g_lsb_first
      // Scan downward; the last set bit seen is the lowest one.
      always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (vec_i[i]) idx_o = IDX_W'(i);
        end
      end
    end
  endgenerate

endmodule : prio_enc_comb
`default_nettype wire

// File: rtl/encoder_8x3_pending.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : encoder_8x3_pending
// Brief  : Sticky-request priority encoder. Request lines accumulate into a
//          pending vector; one index at a time is presented on a valid/ready
//          handshake and cleared from pending when accepted. A presented
//          index is never preempted. Supports N up to 32.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module encoder_8x3_pending
  import encoder_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int IDX_W     = $clog2(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  encoder_8x3_pending_if.slave   bus
);

  enc_state_t       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             drop_q, drop_d;

  logic             w_hs;
  logic [N-1:0]     w_clr_mask;
  logic [IDX_W-1:0] w_enc_idx;
  logic             w_enc_any;

  // Pending update: clear the accepted bit, then OR in new requests so a
  // re-assertion of the accepted bit in the same cycle keeps it pending.
  always_comb begin
    w_hs       = out_valid_q & bus.out_ready;
    w_clr_mask = w_hs ? N'(onehot(32'(out_idx_q))) : '0;
    pend_d     = (pend_q & ~w_clr_mask) | bus.req_in;
    drop_d     = |(bus.req_in & pend_q & ~w_clr_mask);
  end

  prio_enc_comb #(
    .N         (N),
    .IDX_W     (IDX_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec_i (pend_d),
    .idx_o (w_enc_idx),
    .any_o (w_enc_any)
  );

  // Presentation FSM: load a new index when idle or when the current one is
  // accepted; otherwise hold index and valid stable.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (w_enc_any) begin
          out_idx_d   = w_enc_idx;
          out_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (w_hs) begin
          if (w_enc_any) begin
            out_idx_d   = w_enc_idx;
            out_valid_d = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, pending and output registers; reset discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      pend_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.pend_o    = pend_q;
  assign bus.drop_o    = drop_q;

endmodule : encoder_8x3_pending
`default_nettype wire

// File: tb/tb_encoder_8x3_pending.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_encoder_8x3_pending
// Brief  : Self-checking bench for encoder_8x3_pending against a behavioural
//          model of the pending set and the presented index.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_encoder_8x3_pending;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  encoder_8x3_pending_if #(.N(8), .IDX_W(3)) bus ();

  encoder_8x3_pending #(.N(8), .IDX_W(3), .MSB_FIRST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: set of pending indices, presented index and valid flag.
  bit m_pend [8];
  int m_idx;
  bit m_valid;
  bit m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_idx   = 0;
    m_valid = 1'b0;
    m_drop  = 1'b0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic [7:0] req, input bit ready);
    bit accepted;
    bit still [8];
    bit found;
    accepted = m_valid && ready;
    m_drop   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      still[i] = m_pend[i] && !(accepted && (i == m_idx));
      if (req[i] && still[i]) m_drop = 1'b1;
      m_pend[i] = still[i] || req[i];
    end
    if (!m_valid || accepted) begin
      found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (!found && m_pend[i]) begin
          m_idx = i;
          found = 1'b1;
        end
      end
      m_valid = found;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_idx",   32'(bus.out_idx),   32'(m_idx));
    chk("pend_o",    32'(bus.pend_o),    32'(m_pend_vec()));
    chk("drop_o",    32'(bus.drop_o),    32'(m_drop));
  endtask

  // Advance one edge, update the model with the inputs seen at that edge,
  // then compare just after the edge.
  task automatic step();
    logic [7:0] req;
    bit rdy;
    req = bus.req_in;
    rdy = bus.out_ready;
    @(posedge clk);
    if (rst_n) model_edge(req, rdy);
    else       model_reset();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    bus.req_in    = 8'hFF;
    bus.out_ready = 1'b0;

    // Reset held with all requests asserted: nothing may be captured.
    repeat (3) step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pend",  32'(bus.pend_o),    32'd0);
    chk("rst_idx",   32'(bus.out_idx),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_idx",   32'(bus.out_idx),   32'd7);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    bus.req_in    = 8'h00;
    bus.out_ready = 1'b1;
    repeat (9) step();

    // Single pulse.
    bus.req_in = 8'h08;
    step();
    chk("pulse_idx", 32'(bus.out_idx), 32'd3);
    bus.req_in = 8'h00;
    step();
    chk("pulse_done_valid", 32'(bus.out_valid), 32'd0);
    chk("pulse_done_pend",  32'(bus.pend_o),    32'd0);

    // Hold, no preemption by a higher-priority arrival.
    bus.out_ready = 1'b0;
    bus.req_in    = 8'h01;
    step();
    bus.req_in = 8'h00;
    repeat (2) step();
    chk("hold_idx", 32'(bus.out_idx), 32'd0);
    bus.req_in = 8'h80;
    step();
    bus.req_in = 8'h00;
    chk("nopre_idx",  32'(bus.out_idx), 32'd0);
    chk("nopre_pend", 32'(bus.pend_o),  32'h81);
    bus.out_ready = 1'b1;
    step();
    chk("after_hold_idx", 32'(bus.out_idx), 32'd7);
    step();

    // Burst: all requests at once, drained MSB first one per cycle.
    bus.req_in = 8'hFF;
    for (int k = 7; k >= 0; k--) begin
      step();
      bus.req_in = 8'h00;
      chk("burst_idx", 32'(bus.out_idx), 32'(k));
    end
    step();
    chk("burst_end_valid", 32'(bus.out_valid), 32'd0);

    // Collision: re-assert on the accept cycle is set-wins, no drop.
    bus.out_ready = 1'b0;
    bus.req_in    = 8'h04;
    step();
    bus.out_ready = 1'b1;
    step();
    chk("coll_idx",  32'(bus.out_idx), 32'd2);
    chk("coll_drop", 32'(bus.drop_o),  32'd0);
    bus.out_ready = 1'b0;
    step();
    chk("drop_pulse", 32'(bus.drop_o), 32'd1);
    bus.req_in = 8'h00;
    step();
    chk("drop_clear", 32'(bus.drop_o), 32'd0);
    bus.out_ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset in the middle of a transfer.
    bus.out_ready = 1'b0;
    bus.req_in    = 8'h3C;
    step();
    bus.req_in = 8'h00;
    step();
    chk("mid_pend", 32'(bus.pend_o), 32'h3C);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

    // Random traffic: sparse multi-hot requests, random ready.
    for (int n = 0; n < 400; n++) begin
      bus.req_in    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      bus.out_ready = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_encoder_8x3_pending
`default_nettype wire
